// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit: shift-add / Booth multiply and restoring divide,
// one bit per cycle, results into HI/LO with a start/busy/done handshake.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULU = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic             qm1_q, qm1_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] dividend_abs, divisor_abs;
    logic [WIDTH:0]   mulu_sum, booth_sum, div_shift, div_diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    assign dividend_abs = (op == OP_DIV && a[WIDTH-1]) ? -a : a;
    assign divisor_abs  = (op == OP_DIV && b[WIDTH-1]) ? -b : b;

    // Accumulator carries one guard bit so Booth (e.g. most-negative squared)
    // and the unsigned add/subtract steps never overflow.
    always_comb begin
        mulu_sum  = acc_q + (mq_q[0] ? {1'b0, a_q} : '0);
        unique case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + {a_q[WIDTH-1], a_q};
            2'b10:   booth_sum = acc_q - {a_q[WIDTH-1], a_q};
            default: booth_sum = acc_q;
        endcase
        div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        q_fix     = qneg_q ? -mq_q : mq_q;
        r_fix     = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = op[1] ? divisor_abs : b;
                    mq_d    = op[1] ? dividend_abs : b;
                    acc_d   = '0;
                    qm1_d   = 1'b0;
                    qneg_d  = (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rneg_d  = (op == OP_DIV) && a[WIDTH-1];
                    dz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = (op[1] && (b == '0)) ? S_FIX : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    unique case (op_q)
                        OP_MULU: begin
                            acc_d = {1'b0, mulu_sum[WIDTH:1]};
                            mq_d  = {mulu_sum[0], mq_q[WIDTH-1:1]};
                        end
                        OP_MUL: begin
                            acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                            mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
                            qm1_d = mq_q[0];
                        end
                        default: begin
                            acc_d = div_diff[WIDTH] ? div_shift : div_diff;
                            mq_d  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};
                        end
                    endcase
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1] && (b_q == '0)) begin
                        hi_d = a_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else if (op_q[1]) begin
                        hi_d = r_fix;
                        lo_d = q_fix;
                    end else begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = mq_q;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed vector table plus abort/ignore sequences for a 32-bit unit, and a
// randomized scoreboard on an 8-bit unit against an integer arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start, flush;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, dz;

    logic        start8, flush8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dz8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_seq u_dut (
        .clock(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .div_zero(dz), .hi(hi), .lo(lo)
    );

    muldiv_seq #(.WIDTH(8)) u_dut8 (
        .clock(clk), .clr(clr), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        bit          b2b;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge where done is seen (or budget expires).
    // lat counts rising edges after the accepting edge.
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("dz_cleared_on_accept", 32'(dz), 32'd0);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
        start8 = 1'b1; op8 = o; a8 = x; b8 = y;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    function automatic void model8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] eh, output logic [7:0] el,
                                   output logic ed);
        int sx, sy, ux, uy, p, q, r;
        sx = {{24{x[7]}}, x};
        sy = {{24{y[7]}}, y};
        ux = {24'd0, x};
        uy = {24'd0, y};
        ed = 1'b0;
        p = 0; q = 0; r = 0;
        if (o == 2'b00) begin
            p = sx * sy;
            eh = p[15:8]; el = p[7:0];
        end else if (o == 2'b01) begin
            p = ux * uy;
            eh = p[15:8]; el = p[7:0];
        end else if (y == 8'd0) begin
            eh = x; el = 8'hFF; ed = 1'b1;
        end else begin
            if (o == 2'b10) begin
                q = sx / sy; r = sx % sy;
            end else begin
                q = ux / uy; r = ux % uy;
            end
            eh = r[7:0]; el = q[7:0];
        end
    endfunction

    initial begin
        int lat;
        bit seen;
        logic [7:0] eh, el;
        logic ed;

        // Divide-by-zero skips RUN: FIX after the accepting edge, DONE one edge later.
        vt[0] = '{2'b00, 32'h00000022, 32'h00000024, 32'h00000000, 32'h000004C8, 1'b0, 33, 1'b0};
        vt[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0};
        vt[2] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b1};
        vt[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0};
        vt[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 1'b0};
        vt[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0};
        vt[6] = '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1,  1'b0};
        vt[7] = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1,  1'b1};
        vt[8] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 1'b0};
        vt[9] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0};

        clr = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_dz", 32'(dz), 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (!vt[i].b2b) @(negedge clk);
            run32(vt[i].op, vt[i].a, vt[i].b, lat);
            chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
            chk($sformatf("vec%0d_dz", i), 32'(dz), 32'(vt[i].dz));
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end
        @(negedge clk);
        chk("done_single_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);

        // Flush partway through RUN: back to IDLE, no done, results untouched.
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_hi_kept", hi, 32'h00000001);
        chk("flush_lo_kept", lo, 32'hFFFFFFFD);

        // Reset in the middle of an operation.
        start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        clr = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("midreset_no_done", 32'(seen), 32'd0);

        // A start while busy must not disturb the running operation.
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 5) begin
                start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
            end else if (lat == 6) begin
                start = 1'b0;
            end
        end
        chk("ignore_lat", lat, 33);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd12);
        @(negedge clk);
        chk("ignore_no_second_op", 32'(busy), 32'd0);

        // 8-bit instance: directed corner then random scoreboard.
        @(negedge clk);
        run8(2'b00, 8'h80, 8'h80, lat);
        chk("w8_hi", 32'(hi8), 32'h40);
        chk("w8_lo", 32'(lo8), 32'h00);
        chk("w8_lat", lat, 9);
        for (int i = 0; i < 1000; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            @(negedge clk);
            run8(ro, ra, rb, lat);
            model8(ro, ra, rb, eh, el, ed);
            chk($sformatf("rnd%0d_hi op%0d a%0h b%0h", i, ro, ra, rb), 32'(hi8), 32'(eh));
            chk($sformatf("rnd%0d_lo op%0d a%0h b%0h", i, ro, ra, rb), 32'(lo8), 32'(el));
            chk($sformatf("rnd%0d_dz", i), 32'(dz8), 32'(ed));
            chk($sformatf("rnd%0d_lat", i), lat, (ro[1] && rb == 8'd0) ? 1 : 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
